mux_rr_sched: RTL and testbench
===============================

Name: mux_rr_sched

Overview:
- Round-robin scheduler that shares one N:1 select mux between N requesters.
- Owns the mux select line and registers the selected data.
- Enforces a maximum tenure per grant and a dead-cycle gap between owners so downstream logic sees clean hand-offs.
- Sits between the pin-level request inputs (ui_in / uio_in) and the output bus (uo_out) inside a tt_um_* top.

Parameters:
- N_REQ, 4, number of requesters; must be ≥2; SEL_W = $clog2(N_REQ).
- DATA_W, 1, width of each requester's data lane.
- MAX_HOLD, 8, maximum consecutive granted cycles while another requester waits; must be ≥1.
- GAP_CYC, 1, idle cycles inserted between releasing one owner and granting the next; must be ≥0.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, synchronous active-low reset, sampled on the clk rising edge.
- req, input, N_REQ, per-requester request level; held high for as long as access is wanted.
- data_in, input, N_REQ*DATA_W, lane i occupies bits [i*DATA_W +: DATA_W].
- grant, output, N_REQ, one-hot current owner; all-zero when no owner.
- sel, output, SEL_W, mux select; holds the last owner index when grant is zero.
- busy, output, 1, high in GRANT state.
- data_out, output, DATA_W, registered data_in lane [sel] while an owner exists, else 0.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, grant=0, sel=0, busy=0, data_out=0, hold_cnt=0, last_ptr=N_REQ-1 (requester 0 has first priority). Reset mid-tenure drops the grant on that same edge; no gap is applied.
- Registered outputs: all outputs are registered.
- Arbitration function: choose the first i with req[i]=1, searching from last_ptr+1 upward with wrap-around modulo N_REQ. A winner updates last_ptr to i.
- IDLE:
  - If req≠0, go to GRANT with the winner. grant/sel/busy become valid on the next edge, one cycle after the req is sampled.
  - Else stay in IDLE.
- GRANT, evaluated each cycle with o = current owner:
  - req[o]=0: release. Go to GAP if GAP_CYC>0, else re-arbitrate immediately (same edge behaviour as IDLE).
  - req[o]=1, hold_cnt=MAX_HOLD-1, and another req pending: forced preempt, same path as release.
  - req[o]=1, hold_cnt=MAX_HOLD-1, and no other req: keep the grant; hold_cnt resets to 0.
  - Otherwise: hold_cnt++.
  - On every new grant, hold_cnt=0.
- Re-arbitration with GAP_CYC=0: the new owner excludes nothing. If only the previous owner requests, it may win again, because round-robin starts at last_ptr+1 and wraps to it.
- GAP:
  - grant=0, busy=0, data_out=0, sel unchanged.
  - gap_cnt counts GAP_CYC cycles, then arbitrates. Go to GRANT if req≠0, else IDLE.
  - Requests that arrive or drop during GAP are only evaluated at the arbitration edge.
- data_out: on each edge, data_out <= (next grant≠0) ? data_in lane [next sel] : 0. The lane value is therefore aligned with the grant of the same cycle.
- Invariants: grant is one-hot or zero; busy == |grant; never two owners; an owner is never preempted before MAX_HOLD cycles.
- Simultaneous events: a release and a new request on the same edge are resolved by the state rules above. Requests with no current owner are served strictly in round-robin order.

Decomposition:
- Shared package mux_sched_pkg:
  - state enum {IDLE, GRANT, GAP} (2-bit encoding).
  - Default constants N_REQ_DEF, MAX_HOLD_DEF, GAP_CYC_DEF.
  - Helper function rr_pick(req, last_ptr) returning {found, idx}.
- Sub-module mux_sel_n: purely combinational N_REQ:1 mux of DATA_W lanes indexed by sel. It is instantiated once, and the scheduler registers its output.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req=4'b1111 → grant=0, sel=0, busy=0, data_out=0 throughout. Release reset → grant=4'b0001 one cycle later.
- Single requester: req=4'b0100 held 20 cycles, data_in lane2=1 → grant=4'b0100 continuously, no preemption, data_out=1. Drop req → grant=0 for 1 cycle (GAP), then IDLE.
- Round-robin rotation: req=4'b1111 held, MAX_HOLD=8, GAP_CYC=1 → grants 0,1,2,3,0, each 8 cycles, separated by exactly one all-zero cycle; sel follows 0,1,2,3,0.
- Early release: owner 1 drops req after 3 cycles while req[3]=1 → grant=0 for 1 cycle, then grant=4'b1000 and hold_cnt restarts at 0.
- GAP_CYC=0 variant: req=4'b0011 held → grant toggles 0001→0010 on consecutive edges with no zero cycle between.
- Mid-tenure reset: owner 2 granted, rst_n=0 for one edge → outputs zero on that edge. After release with req=4'b0100 → priority starts at requester 0, so requester 2 is granted and last_ptr=2.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared types, default constants and the round-robin pick helper for the
// shared-mux scheduler.
package mux_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int N_REQ_DEF    = 4;
    localparam int MAX_HOLD_DEF = 8;
    localparam int GAP_CYC_DEF  = 1;

    // The helper works on a fixed-width request vector so it can live in the
    // package; callers zero-extend their request vector and pass their N_REQ.
    localparam int MAX_REQ = 32;
    localparam int IDX_W   = 5;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First requester at or after last_ptr+1 (mod n); the previous winner is
    // examined last, which is what makes the order round-robin.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   last_ptr,
                                      input int                 n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n && !p.found) begin
                j = int'(last_ptr) + k;
                if (j >= n) j = j - n;
                if (req[j[IDX_W-1:0]]) begin
                    p.found = 1'b1;
                    p.idx   = j[IDX_W-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux_sel_n.sv
// Purely combinational N_REQ:1 selector of DATA_W-wide lanes.
module mux_sel_n #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 1,
    parameter int SEL_W  = 2
) (
    input  logic [SEL_W-1:0]        i_sel,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    output logic [DATA_W-1:0]       o_data
);

    // Lane select; an out-of-range index yields zero rather than X.
    // NOTE: the default assignment before the loop keeps this block free of
    // inferred latches when no index matches.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_sel == SEL_W'(i)) o_data = i_data[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin owner of a shared N:1 mux: one-hot grant, bounded tenure while
// others wait, optional idle gap between owners, registered lane data.
module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter  int N_REQ    = N_REQ_DEF,
    parameter  int DATA_W   = 1,
    parameter  int MAX_HOLD = MAX_HOLD_DEF,
    parameter  int GAP_CYC  = GAP_CYC_DEF,
    localparam int SEL_W    = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    output logic [N_REQ-1:0]        grant,
    output logic [SEL_W-1:0]        sel,
    output logic                    busy,
    output logic [DATA_W-1:0]       data_out
);

    localparam int HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    state_t              r_state;
    logic [N_REQ-1:0]    r_grant;
    logic [SEL_W-1:0]    r_sel;
    logic                r_busy;
    logic [DATA_W-1:0]   r_data_out;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [SEL_W-1:0]    r_last_ptr;

    pick_t               w_pick;
    logic [SEL_W-1:0]    w_idx;
    logic                w_unused_idx;
    logic                w_last_hold;
    logic                w_others;
    logic                w_keep;
    logic                w_release;
    logic                w_arb;
    logic [SEL_W-1:0]    w_mux_sel;
    logic [DATA_W-1:0]   w_lane;

    // Candidate winner and the keep / release / arbitrate decision for this edge.
    always_comb begin
        w_pick       = rr_pick(MAX_REQ'(req), IDX_W'(r_last_ptr), N_REQ);
        w_idx        = w_pick.idx[SEL_W-1:0];
        w_unused_idx = ^w_pick.idx;
        w_last_hold  = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
        w_others     = |(req & ~r_grant);
        w_keep       = (r_state == GRANT) && req[r_sel] && !(w_last_hold && w_others);
        w_release    = (r_state == GRANT) && !w_keep;
        w_arb        = (r_state == IDLE)
                    || (w_release && GAP_CYC == 0)
                    || (r_state == GAP && r_gap_cnt == GAP_W'(GAP_LAST));
        // The lane is chosen by the select that will be valid after this edge,
        // so registered data lines up with the grant of the same cycle.
        w_mux_sel    = w_keep ? r_sel : w_idx;
    end

    mux_sel_n #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_mux (
        .i_sel  (w_mux_sel),
        .i_data (data_in),
        .o_data (w_lane)
    );

    // Scheduler FSM with registered outputs; reset drops any grant at once.
    // NOTE: every state register here uses <= so all of them update from the
    // same pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_sel      <= '0;
            r_busy     <= 1'b0;
            r_data_out <= '0;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            r_last_ptr <= SEL_W'(N_REQ - 1);
        end else if (w_arb) begin
            if (w_pick.found) begin
                r_state    <= GRANT;
                r_grant    <= ONE_HOT0 << w_idx;
                r_sel      <= w_idx;
                r_busy     <= 1'b1;
                r_data_out <= w_lane;
                r_hold_cnt <= '0;
                r_last_ptr <= w_idx;
            end else begin
                r_state    <= IDLE;
                r_grant    <= '0;
                r_busy     <= 1'b0;
                r_data_out <= '0;
            end
        end else begin
            case (r_state)
                GRANT: begin
                    if (w_keep) begin
                        r_hold_cnt <= w_last_hold ? '0 : r_hold_cnt + 1'b1;
                        r_data_out <= w_lane;
                    end else begin
                        r_state    <= GAP;
                        r_gap_cnt  <= '0;
                        r_grant    <= '0;
                        r_busy     <= 1'b0;
                        r_data_out <= '0;
                    end
                end
                GAP:     r_gap_cnt <= r_gap_cnt + 1'b1;
                default: r_state   <= IDLE;
            endcase
        end
    end

    assign grant    = r_grant;
    assign sel      = r_sel;
    assign busy     = r_busy;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench: two schedulers (GAP_CYC=1 and GAP_CYC=0) share the
// same stimulus and are compared every cycle against a behavioural model.
module tb_mux_rr_sched;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data_in;

    logic [3:0] g1, g0;
    logic [1:0] s1, s0;
    logic       b1, b0;
    logic       d1, d0;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  cmp_en = 1'b0;

    always #5 clk = ~clk;

    mux_rr_sched #(.N_REQ(4), .DATA_W(1), .MAX_HOLD(MAX_HOLD), .GAP_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .grant(g1), .sel(s1), .busy(b1), .data_out(d1)
    );

    mux_rr_sched #(.N_REQ(4), .DATA_W(1), .MAX_HOLD(MAX_HOLD), .GAP_CYC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .grant(g0), .sel(s0), .busy(b0), .data_out(d0)
    );

    // Behavioural model: owner (-1 = none), cycles held in the current window,
    // remaining gap cycles, last winner, visible select and data.
    typedef struct {
        int owner;
        int tenure;
        int gap_left;
        int last;
        int sel;
        bit dout;
    } mdl_t;

    mdl_t m1, m0;

    function automatic int pick(logic [3:0] r, int last);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (last + k) % 4;
            if (r[j[1:0]]) return j;
        end
        return -1;
    endfunction

    function automatic mdl_t step(mdl_t m, logic rst, logic [3:0] r, logic [3:0] d, int gap);
        bit arb;
        bit others;
        int p;
        arb = 1'b0;
        if (!rst) begin
            m.owner = -1; m.tenure = 0; m.gap_left = 0;
            m.last = 3; m.sel = 0; m.dout = 1'b0;
            return m;
        end
        if (m.owner >= 0) begin
            others = (r & ~(4'b0001 << m.owner)) != 4'b0000;
            if (r[m.owner[1:0]] && !(m.tenure == MAX_HOLD && others)) begin
                m.tenure = (m.tenure == MAX_HOLD) ? 1 : m.tenure + 1;
                m.dout   = d[m.owner[1:0]];
                return m;
            end
            m.owner = -1;
            m.dout  = 1'b0;
            if (gap > 0) m.gap_left = gap;
            else         arb = 1'b1;
        end else if (m.gap_left > 0) begin
            m.gap_left = m.gap_left - 1;
            arb = (m.gap_left == 0);
        end else begin
            arb = 1'b1;
        end
        if (arb) begin
            p = pick(r, m.last);
            if (p >= 0) begin
                m.owner = p; m.last = p; m.sel = p; m.tenure = 1;
                m.dout  = d[p[1:0]];
            end
        end
        return m;
    endfunction

    function automatic logic [3:0] e_grant(mdl_t m);
        return (m.owner >= 0) ? (4'b0001 << m.owner) : 4'b0000;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on the same edge as the DUTs, from the same inputs.
    always @(posedge clk) begin
        m1 = step(m1, rst_n, req, data_in, 1);
        m0 = step(m0, rst_n, req, data_in, 0);
    end

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("gap1_grant", 32'(g1), 32'(e_grant(m1)));
            check("gap1_sel",   32'(s1), 32'(m1.sel));
            check("gap1_busy",  32'(b1), 32'(m1.owner >= 0));
            check("gap1_data",  32'(d1), 32'(m1.dout));
            check("gap0_grant", 32'(g0), 32'(e_grant(m0)));
            check("gap0_sel",   32'(s0), 32'(m0.sel));
            check("gap0_busy",  32'(b0), 32'(m0.owner >= 0));
            check("gap0_data",  32'(d0), 32'(m0.dout));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 4'b1111;
        data_in = 4'b1010;

        // Reset held two cycles with every requester active.
        cyc(1);
        cmp_en = 1'b1;
        check("rst_grant_c1", 32'(g1), 32'h0);
        check("rst_busy_c1",  32'(b1), 32'h0);
        cyc(1);
        check("rst_grant_c2", 32'(g1), 32'h0);
        check("rst_sel_c2",   32'(s1), 32'h0);
        check("rst_data_c2",  32'(d1), 32'h0);

        // Rotation 0,1,2,3,0 with 8-cycle tenures and one zero cycle between.
        rst_n = 1'b1;
        cyc(1);
        check("rot_first_grant", 32'(g1), 32'h1);
        check("rot_first_busy",  32'(b1), 32'h1);
        check("model_owner_pin", 32'(m1.owner), 32'h0);
        cyc(7);
        check("rot_grant0_end",  32'(g1), 32'h1);
        cyc(1);
        check("rot_gap_cycle",   32'(g1), 32'h0);
        check("rot_gap_sel",     32'(s1), 32'h0);
        check("gap0_preempt",    32'(g0), 32'h2);
        cyc(1);
        check("rot_grant1",      32'(g1), 32'h2);
        check("rot_sel1",        32'(s1), 32'h1);
        cyc(27);
        check("rot_wrap_grant0", 32'(g1), 32'h1);
        check("rot_wrap_sel0",   32'(s1), 32'h0);

        // Single requester on lane 2 holds without preemption.
        req = 4'b0100; data_in = 4'b0100;
        cyc(1);
        check("single_release",  32'(g1), 32'h0);
        cyc(1);
        check("single_grant",    32'(g1), 32'h4);
        cyc(19);
        check("single_hold",     32'(g1), 32'h4);
        check("single_data",     32'(d1), 32'h1);
        req = 4'b0000;
        cyc(1);
        check("single_drop_gap", 32'(g1), 32'h0);
        cyc(1);
        check("single_idle",     32'(b1), 32'h0);
        check("single_idle_sel", 32'(s1), 32'h2);

        // Early release of owner 1 while requester 3 waits.
        req = 4'b0010; data_in = 4'b1011;
        cyc(1);
        check("early_grant1",    32'(g1), 32'h2);
        req = 4'b1010;
        cyc(2);
        req = 4'b1000;
        cyc(1);
        check("early_gap",       32'(g1), 32'h0);
        cyc(1);
        check("early_grant3",    32'(g1), 32'h8);
        req = 4'b1001;
        cyc(7);
        check("early_hold_full", 32'(g1), 32'h8);
        cyc(1);
        check("early_preempt",   32'(g1), 32'h0);
        cyc(1);
        check("early_next0",     32'(g1), 32'h1);

        // Mid-tenure reset while owner 2 is granted.
        req = 4'b0100;
        cyc(2);
        check("mid_owner2",      32'(g1), 32'h4);
        rst_n = 1'b0;
        cyc(1);
        check("mid_rst_grant",   32'(g1), 32'h0);
        check("mid_rst_sel",     32'(s1), 32'h0);
        check("mid_rst_busy",    32'(b1), 32'h0);
        check("mid_rst_data",    32'(d1), 32'h0);
        rst_n = 1'b1;
        cyc(1);
        check("mid_regrant",     32'(g1), 32'h4);
        check("mid_regrant_sel", 32'(s1), 32'h2);

        // Zero-gap variant: back-to-back hand-off between 0 and 1.
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1; req = 4'b0011;
        cyc(1);
        check("g0_first",        32'(g0), 32'h1);
        cyc(7);
        check("g0_hold_end",     32'(g0), 32'h1);
        cyc(1);
        check("g0_handoff",      32'(g0), 32'h2);

        // Randomized traffic with occasional resets, checked by the model.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            end
            data_in = 4'($urandom);
            rst_n   = ($urandom_range(299) != 0);
            cyc(1);
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
